// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: datapath width, canonical NOP and the
// {pc, instruction} entry carried from the fetch buffer to decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush, combinational head output and
// occupancy count. Used for both the instruction buffer and the request-PC queue.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, memory requests, in-order buffering and
// decode handshake with redirect flush. FETCH_PERF_CNT_EN adds performance counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instruction,
`ifdef FETCH_PERF_CNT_EN
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`else
  output logic [XLEN-1:0] id_pc
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   inflight, buf_count;
  logic [XLEN-1:0] pcq_head;
  logic [OW-1:0]   occupancy;
  logic            accept, pop, push;
  fetch_entry_t    buf_head, buf_entry;

  // Occupancy counts both outstanding requests and buffered instructions, so
  // every accepted request is guaranteed a buffer slot when it returns.
  always_comb begin
    pop            = id_valid && id_ready && !redirect_valid;
    occupancy      = {1'b0, inflight} + {1'b0, buf_count} - OW'(pop);
    imem_req_valid = !rst && !redirect_valid && (occupancy < OW'(DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    buf_entry.pc          = pcq_head;
    buf_entry.instruction = imem_rsp_data;
    id_valid       = !rst && (buf_count != '0);
    id_instruction = id_valid ? buf_head.instruction : NOP_INSTR;
    id_pc          = id_valid ? buf_head.pc : '0;
  end

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (accept) pc_d = pc_q + XLEN'(4);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    // Everything still outstanding after this cycle's response belongs to the old path.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = inflight - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (buf_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // Request PCs are never flushed: stale responses still arrive and must be popped.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .head      (pcq_head),
    .count     (inflight)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(accept);
    perf_stall_d = perf_stall_q + 32'(!id_valid && !rst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
